// File: rtl/i2s_apb_feeder_if.sv
// Bundle between an upstream sample/control source and the I2S APB feeder,
// carrying the sample stream, control requests and the APB write port to I2S_top.
interface i2s_apb_feeder_if #(
  parameter int GAP_W = 16
);
  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;
  logic             ctrl_wr;
  logic [31:0]      ctrl_word;
  logic             stream_en;
  logic [GAP_W-1:0] gap_cycles;
  logic             penable;
  logic             pwrite;
  logic [31:0]      paddr;
  logic [31:0]      pwdata;
  logic             busy;
  logic [15:0]      sent_count;

  modport master (
    output s_valid, s_data, ctrl_wr, ctrl_word, stream_en, gap_cycles,
    input  s_ready, penable, pwrite, paddr, pwdata, busy, sent_count
  );

  modport slave (
    input  s_valid, s_data, ctrl_wr, ctrl_word, stream_en, gap_cycles,
    output s_ready, penable, pwrite, paddr, pwdata, busy, sent_count
  );
endinterface

// File: rtl/i2s_apb_feeder.sv
// Buffers audio samples and feeds them, plus queued control words, to I2S_top
// as two-cycle APB writes, with a programmable idle gap after each data write.
module i2s_apb_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 16
) (
  input logic             pclk,
  input logic             preset,
  i2s_apb_feeder_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] CFG_SETUP   = 3'd1;
  localparam logic [2:0] CFG_ACCESS  = 3'd2;
  localparam logic [2:0] DATA_SETUP  = 3'd3;
  localparam logic [2:0] DATA_ACCESS = 3'd4;

  localparam logic [31:0] ADDR_TX   = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_0004;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [31:0]      shadow;
  logic             ctrl_pend;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      sent_count;
  logic             penable_q;
  logic             pwrite_q;
  logic [31:0]      paddr_q;
  logic [31:0]      pwdata_q;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.s_valid && !full;
  assign pop   = (state == DATA_ACCESS);

  // Control writes win over data and ignore the gap; data waits for the gap to expire.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_pend)
          state_nxt = CFG_SETUP;
        else if (bus.stream_en && !empty && (gap_cnt == '0))
          state_nxt = DATA_SETUP;
      end
      CFG_SETUP:  state_nxt = CFG_ACCESS;
      DATA_SETUP: state_nxt = DATA_ACCESS;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push)
      mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shadow     <= '0;
      ctrl_pend  <= 1'b0;
      gap_cnt    <= '0;
      sent_count <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state <= state_nxt;

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;

      // The shadow value is captured when the write launches, so a request
      // arriving anywhere during the transfer stays pending for the next one.
      if (bus.ctrl_wr) begin
        shadow    <= bus.ctrl_word;
        ctrl_pend <= 1'b1;
      end else if (state_nxt == CFG_SETUP) begin
        ctrl_pend <= 1'b0;
      end

      if (state == DATA_ACCESS)
        gap_cnt <= bus.gap_cycles;
      else if ((state == IDLE) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;

      if (state == DATA_ACCESS)
        sent_count <= sent_count + 16'd1;

      // APB outputs are registered alongside the state so they hold across SETUP->ACCESS.
      case (state_nxt)
        CFG_SETUP: begin
          penable_q <= 1'b0;
          pwrite_q  <= 1'b1;
          paddr_q   <= ADDR_CTRL;
          pwdata_q  <= shadow;
        end
        DATA_SETUP: begin
          penable_q <= 1'b0;
          pwrite_q  <= 1'b1;
          paddr_q   <= ADDR_TX;
          pwdata_q  <= mem[rd_ptr];
        end
        CFG_ACCESS, DATA_ACCESS: begin
          penable_q <= 1'b1;
        end
        default: begin
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
          paddr_q   <= '0;
          pwdata_q  <= '0;
        end
      endcase
    end
  end

  assign bus.s_ready    = !full;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.sent_count = sent_count;
  assign bus.busy       = (state != IDLE) || ctrl_pend || (gap_cnt != '0);
endmodule
